// File: rtl/vertical_window_buffer_7x1.sv
// Vertical window line buffer.
// Takes a raster stream of FP words and, for each column position, presents
// the WINDOW_HEIGHT-tall vertical stack ending at the current row. The centre
// pixel's coordinates are reported alongside the window. Words are only
// stored and moved, never interpreted. A window is flagged valid only when
// every row in it belongs to the current frame.
module vertical_window_buffer_7x1 #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int WINDOW_HEIGHT = 7,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int HALF          = (WINDOW_HEIGHT - 1) / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic                    valid_i,
    input  logic                    sof_i,
    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int LINES = WINDOW_HEIGHT - 1;
    localparam int AW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    // line_mem[k] holds row (current row - (LINES - k)); [0] is the oldest.
    // Contents are deliberately not reset: the valid rule keeps stale words
    // from ever being flagged valid.
    logic [FP_WIDTH_REG-1:0] line_mem [LINES][IMAGE_WIDTH];

    logic [15:0]   cin;
    logic [15:0]   rin;
    logic [15:0]   tag_col;
    logic [15:0]   tag_row;
    logic [AW-1:0] addr;

    // Position tag of the current beat; a start-of-frame beat is forced to (0,0).
    always_comb begin
        tag_col = cin;
        tag_row = rin;
        if (sof_i) begin
            tag_col = '0;
            tag_row = '0;
        end
        addr = tag_col[AW-1:0];
    end

    // Raster position counters, advanced once per accepted beat.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cin <= '0;
            rin <= '0;
        end else if (valid_i) begin
            if (tag_col == 16'(IMAGE_WIDTH - 1)) begin
                cin <= '0;
                rin <= (tag_row == 16'(IMAGE_HEIGHT - 1)) ? '0 : tag_row + 16'd1;
            end else begin
                cin <= tag_col + 16'd1;
                rin <= tag_row;
            end
        end
    end

    // Shift the column at addr one line older and insert the new word as newest.
    always_ff @(posedge clk_i) begin
        if (rst_i && valid_i) begin
            for (int k = 0; k < LINES - 1; k++) begin
                line_mem[k][addr] <= line_mem[k+1][addr];
            end
            line_mem[LINES-1][addr] <= data_i;
        end
    end

    // Registered window and centre coordinates; held across input gaps.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
            for (int k = 0; k < WINDOW_HEIGHT; k++) begin
                window_o[k][0] <= '0;
            end
        end else begin
            valid_o <= valid_i && (tag_row >= 16'(WINDOW_HEIGHT - 1));
            if (valid_i) begin
                col_o <= tag_col;
                row_o <= tag_row - 16'(HALF);
                for (int k = 0; k < LINES; k++) begin
                    window_o[k][0] <= line_mem[k][addr];
                end
                window_o[LINES][0] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_vertical_window_buffer_7x1.sv
// Bench for the vertical window buffer, 8x10 image, 16-bit words.
// A reference model keeps the current frame as a 2-D pixel array indexed by
// a linear beat number, and derives each expected window directly from it.
module tb_vertical_window_buffer_7x1;

    localparam int W  = 8;
    localparam int H  = 10;
    localparam int WH = 7;
    localparam int DW = 16;

    logic          clk;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          sof_i;
    logic [DW-1:0] window_o [WH][1];
    logic [15:0]   col_o;
    logic [15:0]   row_o;
    logic          valid_o;

    vertical_window_buffer_7x1 #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .sof_i   (sof_i),
        .window_o(window_o),
        .col_o   (col_o),
        .row_o   (row_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    // reference model state
    int          nxt;
    logic [15:0] pix [H][W];
    logic        exp_valid;
    logic [15:0] exp_col;
    logic [15:0] exp_row;
    logic [15:0] exp_win [WH];
    bit          win_known;
    logic [15:0] last_data;

    int n_vec;
    int n_err;

    function automatic logic [15:0] rc_data();
        rc_data = {8'(nxt / W), 8'(nxt % W)};
    endfunction

    // drive one cycle of input and advance the model
    task automatic apply(input bit v, input bit s, input logic [15:0] d);
        int idx;
        int c;
        int r;
        @(negedge clk);
        rst_i   = 1'b1;
        valid_i = v;
        sof_i   = s;
        data_i  = d;
        exp_valid = 1'b0;
        if (v) begin
            idx = s ? 0 : nxt;
            c = idx % W;
            r = idx / W;
            pix[r][c] = d;
            last_data = d;
            exp_col = 16'(c);
            exp_row = 16'(r - 3);
            if (r >= WH - 1) begin
                exp_valid = 1'b1;
                for (int k = 0; k < WH; k++) exp_win[k] = pix[r - (WH - 1) + k][c];
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            nxt = (idx + 1) % (W * H);
        end
    endtask

    task automatic model_reset();
        nxt = 0;
        exp_valid = 1'b0;
        exp_col = '0;
        exp_row = '0;
        for (int k = 0; k < WH; k++) exp_win[k] = '0;
        win_known = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b0;
        valid_i = 1'b1;
        sof_i = 1'b0;
        data_i = 16'hBEEF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({valid_o, col_o, row_o} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_ctl: got v=%0b c=%0d r=%0d, expected all 0", valid_o, col_o, row_o);
        end
        for (int k = 0; k < WH; k++) begin
            n_vec++;
            if (window_o[k][0] !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_win[%0d]: got %h expected 0000", k, window_o[k][0]);
            end
        end
    endtask

    task automatic test_full_frame();
        int pulses;
        logic [15:0] lc, lr, lw6;
        pulses = 0;
        lc = '0; lr = '0; lw6 = '0;
        for (int b = 0; b < W * H; b++) begin
            apply(1'b1, b == 0, rc_data());
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL full_ctl b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL full_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (valid_o) begin
                pulses++;
                if (pulses == 1) begin
                    n_vec++;
                    if (col_o !== 16'd0 || row_o !== 16'd3) begin
                        n_err++;
                        $display("FAIL full_first_pos: got c=%0d r=%0d expected c=0 r=3", col_o, row_o);
                    end
                    for (int k = 0; k < WH; k++) begin
                        n_vec++;
                        if (window_o[k][0] !== 16'(k * 256)) begin
                            n_err++;
                            $display("FAIL full_first_win k=%0d: got %h expected %h", k, window_o[k][0], 16'(k * 256));
                        end
                    end
                end
                lc = col_o; lr = row_o; lw6 = window_o[WH-1][0];
            end
        end
        n_vec++;
        if (pulses !== 32) begin
            n_err++;
            $display("FAIL full_pulses: got %0d expected 32", pulses);
        end
        n_vec++;
        if ({lc, lr, lw6} !== {16'd7, 16'd6, 16'h0907}) begin
            n_err++;
            $display("FAIL full_last: got c=%0d r=%0d w6=%h expected c=7 r=6 w6=0907", lc, lr, lw6);
        end
    endtask

    task automatic test_gaps();
        int pulses;
        pulses = 0;
        for (int b = 0; b < W * H * 3; b++) begin
            if (b % 3 == 0) apply(1'b1, b == 0, rc_data());
            else            apply(1'b0, 1'b0, 16'($urandom));
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL gaps_ctl b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL gaps_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (valid_o) pulses++;
        end
        n_vec++;
        if (pulses !== 32) begin
            n_err++;
            $display("FAIL gaps_pulses: got %0d expected 32", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        bit v;
        pulses = 0;
        for (int b = 0; b < 2 * W * H; b++) begin
            apply(1'b1, b == 0, 16'($urandom));
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL b2b_ctl b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL b2b_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (valid_o) pulses++;
            // occasional idle cycle keeps the stream irregular
            v = ($urandom_range(0, 3) == 0);
            if (v) begin
                apply(1'b0, 1'b0, 16'($urandom));
                @(posedge clk); #1;
                n_vec++;
                if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                    n_err++;
                    $display("FAIL b2b_gap b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                             b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
                end
            end
        end
        n_vec++;
        if (pulses !== 64) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d expected 64", pulses);
        end
    endtask

    task automatic test_sof_mid();
        logic [15:0] d48;
        for (int b = 0; b < 4 * W + 5; b++) apply(1'b1, b == 0, 16'($urandom));
        for (int b = 0; b < W * H; b++) begin
            apply(1'b1, b == 0, 16'($urandom));
            if (b == 48) d48 = last_data;
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL sof_ctl b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL sof_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (b < 48) begin
                n_vec++;
                if (valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL sof_quiet b=%0d: got valid_o=%0b expected 0", b, valid_o);
                end
            end else if (b == 48) begin
                n_vec++;
                if ({valid_o, col_o, row_o, window_o[WH-1][0]} !== {1'b1, 16'd0, 16'd3, d48}) begin
                    n_err++;
                    $display("FAIL sof_first: got v=%0b c=%0d r=%0d w6=%h expected v=1 c=0 r=3 w6=%h",
                             valid_o, col_o, row_o, window_o[WH-1][0], d48);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int b = 0; b < 50; b++) apply(1'b1, b == 0, 16'($urandom));
        @(negedge clk);
        rst_i = 1'b0;
        valid_i = 1'b1;
        sof_i = 1'b0;
        data_i = 16'($urandom);
        model_reset();
        @(posedge clk); #1;
        n_vec++;
        if ({valid_o, col_o, row_o} !== 33'd0) begin
            n_err++;
            $display("FAIL rstmid_ctl: got v=%0b c=%0d r=%0d expected all 0", valid_o, col_o, row_o);
        end
        for (int k = 0; k < WH; k++) begin
            n_vec++;
            if (window_o[k][0] !== 16'h0000) begin
                n_err++;
                $display("FAIL rstmid_win[%0d]: got %h expected 0000", k, window_o[k][0]);
            end
        end
        pulses = 0;
        for (int b = 0; b < W * H; b++) begin
            apply(1'b1, 1'b0, rc_data());
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL rstmid_frame b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL rstmid_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (valid_o) pulses++;
        end
        n_vec++;
        if (pulses !== 32) begin
            n_err++;
            $display("FAIL rstmid_pulses: got %0d expected 32", pulses);
        end
    endtask

    task automatic test_idle_beats();
        int pulses;
        pulses = 0;
        for (int b = 0; b < 13; b++) apply(1'b1, 1'b0, rc_data());
        for (int b = 0; b < 20; b++) begin
            apply(1'b0, (b % 2 == 0) ? 1'b1 : 1'($urandom), 16'($urandom));
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL idle_ctl b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
        end
        // remainder of the interrupted frame, then a full frame without sof
        for (int b = 0; b < 2 * W * H - 13; b++) begin
            apply(1'b1, 1'b0, rc_data());
            @(posedge clk); #1;
            n_vec++;
            if ({valid_o, col_o, row_o} !== {exp_valid, exp_col, exp_row}) begin
                n_err++;
                $display("FAIL idle_frame b=%0d: got v=%0b c=%0d r=%0d expected v=%0b c=%0d r=%0d",
                         b, valid_o, col_o, row_o, exp_valid, exp_col, exp_row);
            end
            if (win_known)
                for (int k = 0; k < WH; k++) begin
                    n_vec++;
                    if (window_o[k][0] !== exp_win[k]) begin
                        n_err++;
                        $display("FAIL idle_win b=%0d k=%0d: got %h expected %h", b, k, window_o[k][0], exp_win[k]);
                    end
                end
            if (valid_o && b >= W * H - 13) pulses++;
        end
        n_vec++;
        if (pulses !== 32) begin
            n_err++;
            $display("FAIL idle_pulses: got %0d expected 32", pulses);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst_i = 1'b0;
        valid_i = 1'b0;
        sof_i = 1'b0;
        data_i = '0;
        n_vec = 0;
        n_err = 0;
        last_data = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[r][c] = '0;
        model_reset();
        test_reset();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        test_idle_beats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
